// File: rtl/alu_issue_queue.sv
// Issue queue feeding the alu block: buffers {opcode, op1, op2} entries in a
// small FIFO and presents the oldest one on OPCODE/OP1/OP2.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  parameter int CODEW = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CODEW-1:0]           in_opcode,
  input  logic [OPW-1:0]             in_op1,
  input  logic [OPW-1:0]             in_op2,
  output logic [CODEW-1:0]           OPCODE,
  output logic [OPW-1:0]             OP1,
  output logic [OPW-1:0]             OP2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = CODEW + 2 * OPW;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] count;
  logic          ovf_q;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Ready/valid derive only from the occupancy register, so out_ready never
  // reaches in_ready and a full queue cannot accept even while being popped.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign level     = count;
  assign ovf       = ovf_q;

  assign head = out_valid ? mem[rptr] : '0;
  assign {OPCODE, OP1, OP2} = head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {in_opcode, in_op1, in_op2};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (in_valid && !in_ready) begin
        ovf_q <= 1'b1;
      end
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [3:0] in_op1;
  logic [3:0] in_op2;
  logic [2:0] OPCODE;
  logic [3:0] OP1;
  logic [3:0] OP2;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       ovf;

  logic [10:0] model_q [$];
  logic        model_ovf;
  int          tests    = 0;
  int          failures = 0;

  alu_issue_queue #(.DEPTH(DEPTH), .OPW(4), .CODEW(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2),
    .OPCODE(OPCODE), .OP1(OP1), .OP2(OP2),
    .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference behaviour: a plain FIFO of packed entries plus a sticky flag.
  task automatic modelStep();
    bit can_take;
    bit has_head;
    if (rst) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else if (flush) begin
      model_q.delete();
    end else begin
      can_take = (model_q.size() < DEPTH);
      has_head = (model_q.size() > 0);
      if (in_valid && !can_take) model_ovf = 1'b1;
      if (has_head && out_ready) void'(model_q.pop_front());
      if (in_valid && can_take) model_q.push_back({in_opcode, in_op1, in_op2});
    end
  endtask

  task automatic checkValue(input string tag, input logic [10:0] got, input logic [10:0] exp);
    tests++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [10:0] exp_head;
    exp_head = (model_q.size() > 0) ? model_q[0] : 11'd0;
    checkValue({tag, "/level"},     11'(level),     11'(model_q.size()));
    checkValue({tag, "/out_valid"}, 11'(out_valid), 11'(model_q.size() > 0));
    checkValue({tag, "/in_ready"},  11'(in_ready),  11'(model_q.size() < DEPTH));
    checkValue({tag, "/ovf"},       11'(ovf),       11'(model_ovf));
    checkValue({tag, "/head"},      {OPCODE, OP1, OP2}, exp_head);
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic f,
                               input logic iv, input logic [2:0] op,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_opcode = op;
    in_op1    = a;
    in_op2    = b;
    out_ready = ordy;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic       rv;
    logic       fv;
    logic       iv;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       held;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_op1 = '0; in_op2 = '0;
    model_ovf = 1'b0;

    // Reset then idle
    applyStimulus("rst0", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("rst1", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus("idle", 0, 0, 0, 0, 0, 0, 0);
    checkValue("idle_level", 11'(level), 11'd0);
    checkValue("idle_ready", 11'(in_ready), 11'd1);

    // Single op
    applyStimulus("single_push", 0, 0, 1, 3'b100, 4'b0100, 4'b0000, 0);
    checkValue("single_head", {OPCODE, OP1, OP2}, 11'b100_0100_0000);
    applyStimulus("single_pop", 0, 0, 0, 0, 0, 0, 1);
    checkValue("single_empty", {OPCODE, OP1, OP2}, 11'd0);

    // Fill and overflow
    for (int i = 0; i < DEPTH; i++)
      applyStimulus("fill", 0, 0, 1, 3'(i + 1), 4'(i + 2), 4'(15 - i), 0);
    checkValue("fill_level", 11'(level), 11'd4);
    applyStimulus("overflow", 0, 0, 1, 3'd7, 4'd9, 4'd9, 0);
    checkValue("overflow_flag", 11'(ovf), 11'd1);
    checkValue("overflow_level", 11'(level), 11'd4);
    checkValue("overflow_head", {OPCODE, OP1, OP2}, {3'd1, 4'd2, 4'd15});
    for (int i = 0; i < DEPTH; i++)
      applyStimulus("drain", 0, 0, 0, 0, 0, 0, 1);
    checkValue("drain_ovf", 11'(ovf), 11'd1);

    // Simultaneous push/pop at level 2, across the pointer wrap
    applyStimulus("pp_fill", 0, 0, 1, 3'd2, 4'd3, 4'd4, 0);
    applyStimulus("pp_fill", 0, 0, 1, 3'd3, 4'd5, 4'd6, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus("pp_stream", 0, 0, 1, 3'(i), 4'(i + 7), 4'(i), 1);
    checkValue("pp_level", 11'(level), 11'd2);
    checkValue("pp_head", {OPCODE, OP1, OP2}, {3'd4, 4'd11, 4'd4});

    // Flush with push at level 3
    applyStimulus("fl_fill", 0, 0, 1, 3'd5, 4'd1, 4'd2, 0);
    checkValue("fl_level3", 11'(level), 11'd3);
    applyStimulus("flush", 0, 1, 1, 3'd6, 4'd6, 4'd6, 0);
    checkValue("flush_level", 11'(level), 11'd0);
    checkValue("flush_ovf", 11'(ovf), 11'd1);

    // Reset at level 3 during a pop, then one fresh entry
    for (int i = 0; i < 3; i++)
      applyStimulus("rs_fill", 0, 0, 1, 3'(i), 4'(i), 4'(i), 0);
    applyStimulus("rst_pop", 1, 0, 0, 0, 0, 0, 1);
    checkValue("rst_ovf", 11'(ovf), 11'd0);
    applyStimulus("post_rst_push", 0, 0, 1, 3'd1, 4'd1, 4'd1, 0);
    checkValue("post_rst_head", {OPCODE, OP1, OP2}, {3'd1, 4'd1, 4'd1});
    checkValue("post_rst_level", 11'(level), 11'd1);

    // Random traffic; a refused offer is held stable until accepted
    held = 1'b0;
    op = '0; a = '0; b = '0;
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(99, 0) == 0);
      fv = ($urandom_range(24, 0) == 0);
      if (!held) begin
        iv = 1'($urandom_range(1, 0));
        op = 3'($urandom_range(7, 0));
        a  = 4'($urandom_range(15, 0));
        b  = 4'($urandom_range(15, 0));
      end else begin
        iv = 1'b1;
      end
      applyStimulus("random", rv, fv, iv, op, a, b, 1'($urandom_range(2, 0) == 0));
      held = iv && !rv && !fv && (model_q.size() == DEPTH) && ($urandom_range(1, 0) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
